// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared widths, FSM states and owner-width helper for the schedule arbiter
package sha256_pkg;

   localparam int BLOCK_W = 512;
   localparam int WORD_W  = 32;
   localparam int PAIRS   = 32;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      STREAM,
      COOL
   } state_e;

   function automatic int own_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sha256_sched_arbiter_rr_lock_arbiter.sv
// rtl/sha256_sched_arbiter_rr_lock_arbiter.sv - round-robin pick with per-message lock
// The lock pins eligibility to one owner until that owner's last block is accepted.
module rr_lock_arbiter
   import sha256_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int OWN_W = own_width(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req_valid,
   input  logic             arb_en,
   input  logic             take,
   input  logic             take_last,
   output logic [N_REQ-1:0] grant,
   output logic [OWN_W-1:0] grant_idx,
   output logic             locked
);

   logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [OWN_W-1:0] lock_owner_q, lock_owner_d;
   logic             locked_q, locked_d;
   logic [N_REQ-1:0] eligible;
   logic             found;
   logic [OWN_W:0]   pos;
   logic [OWN_W:0]   nxt;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < N_REQ; i++) begin
         eligible[i] = req_valid[i] & (!locked_q | (lock_owner_q == OWN_W'(i)));
      end
   end

   // Cyclic scan starting at rr_ptr; the first eligible requester wins.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      pos       = '0;
      for (int off = 0; off < N_REQ; off++) begin
         pos = {1'b0, rr_ptr_q} + (OWN_W+1)'(off);
         if (pos >= (OWN_W+1)'(N_REQ)) begin
            pos = pos - (OWN_W+1)'(N_REQ);
         end
         if (!found && eligible[pos[OWN_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = pos[OWN_W-1:0];
         end
      end
   end

   always_comb begin
      grant = '0;
      if (arb_en && found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_owner_d = lock_owner_q;
      locked_d     = locked_q;
      nxt          = {1'b0, grant_idx} + (OWN_W+1)'(1);
      if (take) begin
         if (take_last) begin
            locked_d = 1'b0;
            rr_ptr_d = (nxt >= (OWN_W+1)'(N_REQ)) ? '0 : nxt[OWN_W-1:0];
         end else begin
            locked_d     = 1'b1;
            lock_owner_d = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         lock_owner_q <= '0;
         locked_q     <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_owner_q <= lock_owner_d;
         locked_q     <= locked_d;
      end
   end

   assign locked = locked_q;

endmodule

// File: rtl/sha256_sched_arbiter.sv
// rtl/sha256_sched_arbiter.sv - shares one message_schedule between requesters, re-times W pairs
// Optional SCHED_WATCHDOG_EN adds sticky err_stall / err_spurious outputs.
module sha256_sched_arbiter
   import sha256_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int OWN_W = own_width(N_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*BLOCK_W-1:0] req_block,
   input  logic [N_REQ-1:0]         req_last,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     sched_input_valid,
   output logic [BLOCK_W-1:0]       sched_block,
   input  logic                     sched_valid_in,
   input  logic [WORD_W-1:0]        sched_w0_in,
   input  logic [WORD_W-1:0]        sched_w1_in,
   output logic                     w_valid,
   output logic [WORD_W-1:0]        w0,
   output logic [WORD_W-1:0]        w1,
   output logic [4:0]               w_idx,
   output logic [OWN_W-1:0]         w_owner,
   output logic                     w_first_blk,
   output logic                     block_done,
   output logic                     block_done_last
`ifdef SCHED_WATCHDOG_EN
   ,
   output logic                     err_stall,
   output logic                     err_spurious
`endif
);

   state_e             state_q, state_d;
   logic [BLOCK_W-1:0] blk_q, blk_d;
   logic               launch_q, launch_d;
   logic [OWN_W-1:0]   own_q, own_d;
   logic               last_q, last_d;
   logic               first_q, first_d;
   logic [4:0]         pair_cnt_q, pair_cnt_d;
   logic               w_valid_q, w_valid_d;
   logic [WORD_W-1:0]  w0_q, w0_d;
   logic [WORD_W-1:0]  w1_q, w1_d;
   logic [4:0]         w_idx_q, w_idx_d;
   logic               done_q, done_d;
   logic               done_last_q, done_last_d;
`ifdef SCHED_WATCHDOG_EN
   logic [2:0]         stall_cnt_q, stall_cnt_d;
   logic [5:0]         dur_cnt_q, dur_cnt_d;
   logic               err_stall_q, err_stall_d;
   logic               err_spurious_q, err_spurious_d;
`endif

   logic [N_REQ-1:0]   grant;
   logic [OWN_W-1:0]   grant_idx;
   logic               locked;
   logic               arb_en;
   logic               take;

   assign arb_en = (state_q == IDLE);
   assign take   = |(req_valid & grant);

   rr_lock_arbiter #(
      .N_REQ (N_REQ),
      .OWN_W (OWN_W)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .arb_en    (arb_en),
      .take      (take),
      .take_last (req_last[grant_idx]),
      .grant     (grant),
      .grant_idx (grant_idx),
      .locked    (locked)
   );

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      launch_d    = 1'b0;
      own_d       = own_q;
      last_d      = last_q;
      first_d     = first_q;
      pair_cnt_d  = pair_cnt_q;
      w_valid_d   = 1'b0;
      w0_d        = w0_q;
      w1_d        = w1_q;
      w_idx_d     = w_idx_q;
      done_d      = 1'b0;
      done_last_d = 1'b0;
`ifdef SCHED_WATCHDOG_EN
      stall_cnt_d    = stall_cnt_q;
      dur_cnt_d      = dur_cnt_q;
      err_stall_d    = err_stall_q;
      err_spurious_d = err_spurious_q;
`endif
      case (state_q)
         IDLE: begin
            if (take) begin
               blk_d    = req_block[int'(grant_idx)*BLOCK_W +: BLOCK_W];
               own_d    = grant_idx;
               last_d   = req_last[grant_idx];
               first_d  = !locked;
               launch_d = 1'b1;
               state_d  = LAUNCH;
            end
`ifdef SCHED_WATCHDOG_EN
            if (sched_valid_in) begin
               err_spurious_d = 1'b1;
            end
`endif
         end
         LAUNCH: begin
            pair_cnt_d = '0;
            state_d    = STREAM;
`ifdef SCHED_WATCHDOG_EN
            stall_cnt_d = '0;
            dur_cnt_d   = 6'd1;
`endif
         end
         STREAM: begin
            if (sched_valid_in) begin
               w0_d       = sched_w0_in;
               w1_d       = sched_w1_in;
               w_idx_d    = pair_cnt_q;
               w_valid_d  = 1'b1;
               pair_cnt_d = pair_cnt_q + 5'd1;
               if (pair_cnt_q == 5'(PAIRS-1)) begin
                  done_d      = 1'b1;
                  done_last_d = last_q;
                  state_d     = COOL;
               end
            end
`ifdef SCHED_WATCHDOG_EN
            // Abort a wedged block: the core sees no "last" so it never finalises a digest.
            dur_cnt_d   = dur_cnt_q + 6'd1;
            stall_cnt_d = sched_valid_in ? 3'd0 : stall_cnt_q + 3'd1;
            if ((!sched_valid_in && stall_cnt_q == 3'd3) || dur_cnt_q >= 6'd40) begin
               err_stall_d = 1'b1;
               done_last_d = 1'b0;
               state_d     = COOL;
            end
`endif
         end
         COOL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         blk_q       <= '0;
         launch_q    <= 1'b0;
         own_q       <= '0;
         last_q      <= 1'b0;
         first_q     <= 1'b0;
         pair_cnt_q  <= '0;
         w_valid_q   <= 1'b0;
         w0_q        <= '0;
         w1_q        <= '0;
         w_idx_q     <= '0;
         done_q      <= 1'b0;
         done_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         launch_q    <= launch_d;
         own_q       <= own_d;
         last_q      <= last_d;
         first_q     <= first_d;
         pair_cnt_q  <= pair_cnt_d;
         w_valid_q   <= w_valid_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         w_idx_q     <= w_idx_d;
         done_q      <= done_d;
         done_last_q <= done_last_d;
      end
   end

`ifdef SCHED_WATCHDOG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q    <= '0;
         dur_cnt_q      <= '0;
         err_stall_q    <= 1'b0;
         err_spurious_q <= 1'b0;
      end else begin
         stall_cnt_q    <= stall_cnt_d;
         dur_cnt_q      <= dur_cnt_d;
         err_stall_q    <= err_stall_d;
         err_spurious_q <= err_spurious_d;
      end
   end

   assign err_stall    = err_stall_q;
   assign err_spurious = err_spurious_q;
`endif

   assign req_ready         = grant;
   assign sched_input_valid = launch_q;
   assign sched_block       = blk_q;
   assign w_valid           = w_valid_q;
   assign w0                = w0_q;
   assign w1                = w1_q;
   assign w_idx             = w_idx_q;
   assign w_owner           = own_q;
   assign w_first_blk       = first_q;
   assign block_done        = done_q;
   assign block_done_last   = done_last_q;

endmodule

// File: tb/tb_sha256_sched_arbiter.sv
// tb/tb_sha256_sched_arbiter.sv - directed self-checking bench with a behavioural message_schedule
module tb_sha256_sched_arbiter;

   localparam int N = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [N*512-1:0] req_block = '0;
   logic           sched_input_valid;
   logic [511:0]   sched_block;
   logic           sched_valid_in;
   logic [31:0]    w0, w1;
   logic           w_valid;
   logic [4:0]     w_idx;
   logic [0:0]     w_owner;
   logic           w_first_blk, block_done, block_done_last;
`ifdef SCHED_WATCHDOG_EN
   logic           err_stall, err_spurious;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // behavioural scheduler: first pair one edge after the launch pulse
   logic        m_valid = 1'b0;
   logic        m_act = 1'b0;
   logic        inj_valid = 1'b0;
   logic [31:0] m_w0 = '0, m_w1 = '0;
   logic [511:0] m_blk = '0;
   int          m_k = 0, m_stall = 0;
   int          stall_at = 99, stall_len = 0;

   assign sched_valid_in = m_valid | inj_valid;

   sha256_sched_arbiter #(.N_REQ(N)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_block         (req_block),
      .req_last          (req_last),
      .req_ready         (req_ready),
      .sched_input_valid (sched_input_valid),
      .sched_block       (sched_block),
      .sched_valid_in    (sched_valid_in),
      .sched_w0_in       (m_w0),
      .sched_w1_in       (m_w1),
      .w_valid           (w_valid),
      .w0                (w0),
      .w1                (w1),
      .w_idx             (w_idx),
      .w_owner           (w_owner),
      .w_first_blk       (w_first_blk),
      .block_done        (block_done),
      .block_done_last   (block_done_last)
`ifdef SCHED_WATCHDOG_EN
      ,
      .err_stall         (err_stall),
      .err_spurious      (err_spurious)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] wsched(input logic [511:0] b, input int t);
      logic [31:0] w [64];
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      return w[t];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_act   <= 1'b0;
      end else if (sched_input_valid) begin
         m_blk   <= sched_block;
         m_act   <= 1'b1;
         m_valid <= 1'b1;
         m_w0    <= wsched(sched_block, 0);
         m_w1    <= wsched(sched_block, 1);
         m_k     <= 1;
         m_stall <= stall_len;
      end else if (m_act) begin
         if (m_k == 32) begin
            m_valid <= 1'b0;
            m_act   <= 1'b0;
         end else if (m_k == stall_at && m_stall > 0) begin
            m_valid <= 1'b0;
            m_stall <= m_stall - 1;
         end else begin
            m_valid <= 1'b1;
            m_w0    <= wsched(m_blk, 2*m_k);
            m_w1    <= wsched(m_blk, 2*m_k + 1);
            m_k     <= m_k + 1;
         end
      end
   end

   // monitor: transfers and forwarded beats, sampled on the falling edge
   int          x_own[$], x_cyc[$];
   int          b_idx[$], b_own[$], b_first[$], b_done[$], b_dl[$], b_cyc[$];
   logic [63:0] b_w[$];
   int          n_done = 0;
   bit          watch_r1 = 1'b0, r1_seen = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (|(req_valid & req_ready)) begin
            x_own.push_back(req_ready[1] ? 1 : 0);
            x_cyc.push_back(cyc);
         end
         if (w_valid) begin
            b_idx.push_back(int'(w_idx));
            b_w.push_back({w0, w1});
            b_own.push_back(int'(w_owner));
            b_first.push_back(int'(w_first_blk));
            b_done.push_back(int'(block_done));
            b_dl.push_back(int'(block_done_last));
            b_cyc.push_back(cyc);
         end
         if (block_done) n_done <= n_done + 1;
         if (watch_r1 && req_ready[1]) r1_seen <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear();
      x_own.delete(); x_cyc.delete();
      b_idx.delete(); b_w.delete(); b_own.delete(); b_first.delete();
      b_done.delete(); b_dl.delete(); b_cyc.delete();
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic wait_xfers(input int n, input string tag);
      int t = 0;
      while (x_own.size() < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 64'(x_own.size() >= n), 64'd1);
   endtask

   task automatic wait_done(input int n, input string tag);
      int t = 0;
      while (n_done < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 64'(n_done >= n), 64'd1);
   endtask

   task automatic check_block(input string tag, input int base, input logic [511:0] blk,
                              input int own, input int first, input int last);
      chk({tag, "_nbeats"}, 64'(b_idx.size() >= base + 32), 64'd1);
      if (b_idx.size() < base + 32) return;
      for (int k = 0; k < 32; k++) begin
         chk({tag, "_idx"},   64'(b_idx[base+k]), 64'(k));
         chk({tag, "_w"},     b_w[base+k], {wsched(blk, 2*k), wsched(blk, 2*k+1)});
         chk({tag, "_own"},   64'(b_own[base+k]), 64'(own));
         chk({tag, "_first"}, 64'(b_first[base+k]), 64'(first));
         chk({tag, "_done"},  64'(b_done[base+k]), 64'(k == 31));
         chk({tag, "_dlast"}, 64'(b_dl[base+k]), 64'((k == 31) && (last != 0)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [511:0] blk_abc, blk_b;
      int d0;
      bit hit;

      blk_abc = '0;
      blk_abc[511:480] = 32'h61626380;
      blk_abc[31:0]    = 32'h00000018;
      for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = (32'h01000000 * (i + 1)) ^ 32'h00005a5a;

      // reset values
      step(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_w_valid", 64'(w_valid), 64'd0);
      chk("rst_launch", 64'(sched_input_valid), 64'd0);
      chk("rst_done", 64'({block_done, block_done_last}), 64'd0);
      chk("rst_idx_own_first", 64'({w_idx, w_owner, w_first_blk}), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_sched_block", 64'(|sched_block), 64'd0);
      chk("rst_words", {w0, w1}, 64'd0);

      // single "abc" block from requester 0
      clear();
      step(1);
      req_block[511:0] = blk_abc;
      req_last = 2'b01;
      req_valid = 2'b01;
      wait_xfers(1, "t1_xfer");
      step(1);
      req_valid = '0;
      wait_done(1, "t1_done");
      step(3);
      check_block("t1", 0, blk_abc, 0, 1, 1);
      if (b_w.size() > 8) chk("t1_w16_w17", b_w[8], 64'h61626380_000F0000);
      if (b_cyc.size() > 0 && x_cyc.size() > 0) chk("t1_latency", 64'(b_cyc[0] - x_cyc[0]), 64'd3);

      // both requesters, single blocks, from rr_ptr=0
      reset_pulse();
      clear();
      d0 = n_done;
      req_block = {blk_b, blk_abc};
      req_last = 2'b11;
      req_valid = 2'b11;
      wait_xfers(2, "t2_xfers");
      step(1);
      req_valid = '0;
      wait_done(d0 + 2, "t2_done");
      step(3);
      if (x_own.size() >= 2) begin
         chk("t2_own0", 64'(x_own[0]), 64'd0);
         chk("t2_own1", 64'(x_own[1]), 64'd1);
         chk("t2_interval", 64'(x_cyc[1] - x_cyc[0]), 64'd35);
      end
      check_block("t2a", 0, blk_abc, 0, 1, 1);
      check_block("t2b", 32, blk_b, 1, 1, 1);

      // two-block message from req0 while req1 keeps requesting; lock holds through a gap
      clear();
      d0 = n_done;
      r1_seen = 1'b0;
      watch_r1 = 1'b1;
      req_last = 2'b10;
      req_valid = 2'b11;
      wait_xfers(1, "t3_xfer1");
      step(1);
      req_valid[0] = 1'b0;
      req_last[0] = 1'b1;
      step(50);
      chk("t3_locked_wait", 64'(x_own.size()), 64'd1);
      req_valid[0] = 1'b1;
      wait_xfers(2, "t3_xfer2");
      step(1);
      req_valid[0] = 1'b0;
      watch_r1 = 1'b0;
      chk("t3_r1_ready", 64'(r1_seen), 64'd0);
      wait_xfers(3, "t3_xfer3");
      step(1);
      req_valid = '0;
      wait_done(d0 + 3, "t3_done");
      step(3);
      if (x_own.size() >= 3) chk("t3_owners", 64'({x_own[0][1:0], x_own[1][1:0], x_own[2][1:0]}), 64'b00_00_01);
      check_block("t3a", 0, blk_abc, 0, 1, 0);
      check_block("t3b", 32, blk_abc, 0, 0, 1);
      check_block("t3c", 64, blk_b, 1, 1, 1);

      // reset asserted at pair 10
      clear();
      d0 = n_done;
      req_last = 2'b01;
      req_valid = 2'b01;
      wait_xfers(1, "t4_xfer");
      step(1);
      req_valid = '0;
      hit = 1'b0;
      for (int t = 0; t < 60 && !hit; t++) begin
         @(negedge clk);
         if (w_valid && w_idx == 5'd10) hit = 1'b1;
      end
      chk("t4_reached_pair10", 64'(hit), 64'd1);
      reset = 1'b1;
      #1;
      chk("t4_rst_outputs", 64'({w_valid, block_done, block_done_last, sched_input_valid}), 64'd0);
      chk("t4_rst_idx", 64'(w_idx), 64'd0);
      step(2);
      reset = 1'b0;
      step(40);
      chk("t4_no_done", 64'(n_done), 64'(d0));
      clear();
      req_valid = 2'b01;
      wait_xfers(1, "t4_fresh_xfer");
      step(1);
      req_valid = '0;
      wait_done(d0 + 1, "t4_fresh_done");
      step(3);
      check_block("t4", 0, blk_abc, 0, 1, 1);

      // scheduler drops valid for 2 cycles at pair 5
      clear();
      d0 = n_done;
      stall_at = 5;
      stall_len = 2;
      req_valid = 2'b01;
      wait_xfers(1, "t5_xfer");
      step(1);
      req_valid = '0;
      wait_done(d0 + 1, "t5_done");
      step(3);
      check_block("t5", 0, blk_abc, 0, 1, 1);
      if (b_cyc.size() > 5) chk("t5_gap", 64'(b_cyc[5] - b_cyc[4]), 64'd3);
`ifdef SCHED_WATCHDOG_EN
      chk("t5_no_stall_err", 64'(err_stall), 64'd0);
      d0 = n_done;
      stall_len = 4;
      req_valid = 2'b01;
      wait_xfers(2, "t5w_xfer");
      step(1);
      req_valid = '0;
      step(60);
      chk("t5w_err_stall", 64'(err_stall), 64'd1);
      chk("t5w_no_done", 64'(n_done), 64'(d0));
      reset_pulse();
`endif
      stall_at = 99;
      stall_len = 0;

      // sched_valid_in pulsed while idle
      step(2);
      clear();
      inj_valid = 1'b1;
      step(1);
      inj_valid = 1'b0;
      step(5);
      chk("t6_no_beats", 64'(b_idx.size()), 64'd0);
      chk("t6_w_valid", 64'(w_valid), 64'd0);
`ifdef SCHED_WATCHDOG_EN
      chk("t6_err_spurious", 64'(err_spurious), 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
